// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline instruction-source stage: select codes,
// squash state encoding and the default bubble word.
package pipe_pkg;

    localparam logic [1:0] SEL_NORMAL = 2'b00;
    localparam logic [1:0] SEL_NOP    = 2'b01;
    localparam logic [1:0] SEL_BRANCH = 2'b10;
    localparam logic [1:0] SEL_RSVD   = 2'b11;

    localparam int          SQ_CNT_W         = 4;
    localparam int          SQ_CNT_MAX       = (1 << SQ_CNT_W) - 1;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } squash_state_e;

endpackage

// File: rtl/ir_src_pipe_reg_if.sv
// Control and data bundle between the issuing pipeline stage and the
// instruction-source register.
interface ir_src_pipe_reg_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             flush;
    logic [1:0]       ir_src_sel;
    logic [WIDTH-1:0] ir_normal;
    logic [WIDTH-1:0] ir_branch;
    logic             in_valid;
    logic [WIDTH-1:0] ir_out;
    logic             ir_valid;
    logic             squashing;
    logic [CNT_W-1:0] bubble_count;

    modport master (
        output stall, flush, ir_src_sel, ir_normal, ir_branch, in_valid,
        input  ir_out, ir_valid, squashing, bubble_count
    );

    modport slave (
        input  stall, flush, ir_src_sel, ir_normal, ir_branch, in_valid,
        output ir_out, ir_valid, squashing, bubble_count
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for performance monitoring; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ir_src_pipe_reg.sv
// Registered instruction-source selector: normal / NOP / branch redirect,
// with stall, flush and automatic squash of wrong-path instructions.
module ir_src_pipe_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH         = 32,
    parameter logic [WIDTH-1:0] NOP_WORD      = WIDTH'(DEFAULT_NOP_WORD),
    parameter int               SQUASH_CYCLES = 2,
    parameter int               CNT_W         = 16
) (
    input logic               clk,
    input logic               rst,
    ir_src_pipe_reg_if.slave  bus
);

    // The squash counter is only 4 bits wide, so larger squash depths cannot be honoured.
    if (SQUASH_CYCLES < 0 || SQUASH_CYCLES > SQ_CNT_MAX) begin : g_bad_squash_cycles
        $error("ir_src_pipe_reg: SQUASH_CYCLES=%0d out of range 0..%0d",
               SQUASH_CYCLES, SQ_CNT_MAX);
    end

    localparam logic [SQ_CNT_W-1:0] SQ_LOAD = SQ_CNT_W'(SQUASH_CYCLES);
    localparam squash_state_e BRANCH_STATE = (SQUASH_CYCLES > 0) ? SQUASH : RUN;

    squash_state_e       state_q, state_d;
    logic [SQ_CNT_W-1:0] sq_cnt_q, sq_cnt_d;
    logic [WIDTH-1:0]    ir_q, ir_d;
    logic                valid_q, valid_d;
    logic                bubble_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            sq_cnt_q <= '0;
            ir_q     <= NOP_WORD;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sq_cnt_q <= sq_cnt_d;
            ir_q     <= ir_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sq_cnt_d   = sq_cnt_q;
        ir_d       = ir_q;
        valid_d    = valid_q;
        bubble_inc = 1'b0;

        if (bus.flush) begin
            state_d    = RUN;
            sq_cnt_d   = '0;
            ir_d       = NOP_WORD;
            valid_d    = 1'b0;
            bubble_inc = 1'b1;
        end else if (!bus.stall) begin
            if (bus.ir_src_sel == SEL_BRANCH) begin
                // A redirect always wins and restarts the squash window.
                state_d  = BRANCH_STATE;
                sq_cnt_d = SQ_LOAD;
                ir_d     = bus.ir_branch;
                valid_d  = 1'b1;
            end else if (state_q == SQUASH) begin
                // Every non-redirect slot in SQUASH is a wrong-path bubble.
                ir_d       = NOP_WORD;
                valid_d    = 1'b0;
                bubble_inc = 1'b1;
                sq_cnt_d   = (sq_cnt_q != '0) ? sq_cnt_q - 1'b1 : '0;
                if (sq_cnt_q <= SQ_CNT_W'(1)) begin
                    state_d = RUN;
                end
            end else if (bus.ir_src_sel == SEL_NORMAL) begin
                ir_d       = bus.ir_normal;
                valid_d    = bus.in_valid;
                bubble_inc = ~bus.in_valid;
            end else begin
                ir_d       = NOP_WORD;
                valid_d    = 1'b0;
                bubble_inc = 1'b1;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_inc),
        .clr   (1'b0),
        .count (bus.bubble_count)
    );

    assign bus.ir_out    = ir_q;
    assign bus.ir_valid  = valid_q;
    assign bus.squashing = (state_q == SQUASH);

endmodule

// File: tb/tb_ir_src_pipe_reg.sv
// Directed self-checking bench for ir_src_pipe_reg (4-bit bubble counter so
// saturation is reachable).
module tb_ir_src_pipe_reg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ir_src_pipe_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    ir_src_pipe_reg #(
        .WIDTH         (WIDTH),
        .NOP_WORD      (NOP),
        .SQUASH_CYCLES (2),
        .CNT_W         (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic apply_stimulus(input logic st, input logic fl, input logic [1:0] sel,
                                  input logic [31:0] nrm, input logic [31:0] br,
                                  input logic vld);
        bus.stall      = st;
        bus.flush      = fl;
        bus.ir_src_sel = sel;
        bus.ir_normal  = nrm;
        bus.ir_branch  = br;
        bus.in_valid   = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] e_ir, input logic e_vld,
                                input logic e_sq, input logic [CNT_W-1:0] e_cnt);
        total++;
        assert (bus.ir_out === e_ir) else begin
            bad++;
            $error("[TB] FAIL %s ir_out got=%h exp=%h", tag, bus.ir_out, e_ir);
        end
        total++;
        assert (bus.ir_valid === e_vld) else begin
            bad++;
            $error("[TB] FAIL %s ir_valid got=%b exp=%b", tag, bus.ir_valid, e_vld);
        end
        total++;
        assert (bus.squashing === e_sq) else begin
            bad++;
            $error("[TB] FAIL %s squashing got=%b exp=%b", tag, bus.squashing, e_sq);
        end
        total++;
        assert (bus.bubble_count === e_cnt) else begin
            bad++;
            $error("[TB] FAIL %s bubble_count got=%0d exp=%0d", tag, bus.bubble_count, e_cnt);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.stall = 0; bus.flush = 0; bus.ir_src_sel = 2'b00;
        bus.ir_normal = '0; bus.ir_branch = '0; bus.in_valid = 0;
        #12;
        check_output("reset", NOP, 0, 0, 0);
        rst = 1'b0;

        // Normal flow
        apply_stimulus(0, 0, 2'b00, 32'h2002_0005, 32'h0, 1);
        check_output("normal", 32'h2002_0005, 1, 0, 0);

        // Redirect followed by two squashed slots
        apply_stimulus(0, 0, 2'b10, 32'h1111_1111, 32'h0800_0010, 1);
        check_output("br_e1", 32'h0800_0010, 1, 1, 0);
        apply_stimulus(0, 0, 2'b00, 32'h1111_1111, 32'h0, 1);
        check_output("br_e2", NOP, 0, 1, 1);
        apply_stimulus(0, 0, 2'b00, 32'h2222_2222, 32'h0, 1);
        check_output("br_e3", NOP, 0, 0, 2);
        apply_stimulus(0, 0, 2'b00, 32'h3333_3333, 32'h0, 1);
        check_output("br_e4", 32'h3333_3333, 1, 0, 2);

        // Redirect during SQUASH
        do_reset();
        apply_stimulus(0, 0, 2'b10, 32'h0, 32'h0800_0010, 1);
        check_output("rr_b1", 32'h0800_0010, 1, 1, 0);
        apply_stimulus(0, 0, 2'b00, 32'h9999_9999, 32'h0, 1);
        check_output("rr_n1", NOP, 0, 1, 1);
        apply_stimulus(0, 0, 2'b10, 32'h9999_9999, 32'h0800_0020, 1);
        check_output("rr_b2", 32'h0800_0020, 1, 1, 1);
        apply_stimulus(0, 0, 2'b00, 32'h9999_9999, 32'h0, 1);
        check_output("rr_n2", NOP, 0, 1, 2);
        apply_stimulus(0, 0, 2'b00, 32'h9999_9999, 32'h0, 1);
        check_output("rr_n3", NOP, 0, 0, 3);
        apply_stimulus(0, 0, 2'b00, 32'h4444_4444, 32'h0, 1);
        check_output("rr_run", 32'h4444_4444, 1, 0, 3);

        // Stall mid-squash freezes everything
        do_reset();
        apply_stimulus(0, 0, 2'b10, 32'h0, 32'h0800_0030, 1);
        check_output("st_br", 32'h0800_0030, 1, 1, 0);
        apply_stimulus(0, 0, 2'b00, 32'hAAAA_AAAA, 32'h0, 1);
        check_output("st_n1", NOP, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 0, 2'b10, 32'hAAAA_AAAA, 32'hDEAD_BEEF, 1);
            check_output("st_hold", NOP, 0, 1, 1);
        end
        apply_stimulus(0, 0, 2'b00, 32'hAAAA_AAAA, 32'h0, 1);
        check_output("st_n2", NOP, 0, 0, 2);
        apply_stimulus(0, 0, 2'b00, 32'h5555_5555, 32'h0, 1);
        check_output("st_run", 32'h5555_5555, 1, 0, 2);

        // Flush beats stall and cancels the squash
        apply_stimulus(0, 0, 2'b10, 32'h0, 32'h6666_6666, 1);
        check_output("fl_br", 32'h6666_6666, 1, 1, 2);
        apply_stimulus(1, 1, 2'b00, 32'hBBBB_BBBB, 32'h0, 1);
        check_output("fl_stall", NOP, 0, 0, 3);
        apply_stimulus(0, 0, 2'b00, 32'h7777_7777, 32'h0, 1);
        check_output("fl_run", 32'h7777_7777, 1, 0, 3);

        // Reserved select and invalid normal instruction
        apply_stimulus(0, 0, 2'b11, 32'hFFFF_FFFF, 32'h0, 1);
        check_output("rsvd", NOP, 0, 0, 4);
        apply_stimulus(0, 0, 2'b00, 32'h1234_5678, 32'h0, 0);
        check_output("inval", 32'h1234_5678, 0, 0, 5);

        // Bubble counter saturation
        do_reset();
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(0, 0, 2'b01, 32'h0, 32'h0, 1);
        end
        check_output("sat_15", NOP, 0, 0, 4'hF);
        apply_stimulus(0, 0, 2'b01, 32'h0, 32'h0, 1);
        check_output("sat_16", NOP, 0, 0, 4'hF);
        apply_stimulus(1, 1, 2'b00, 32'h0, 32'h0, 1);
        check_output("sat_fl", NOP, 0, 0, 4'hF);

        // Asynchronous reset mid-squash
        do_reset();
        apply_stimulus(0, 0, 2'b01, 32'h0, 32'h0, 1);
        apply_stimulus(0, 0, 2'b10, 32'h0, 32'h0800_0040, 1);
        check_output("ar_pre", 32'h0800_0040, 1, 1, 1);
        #2;
        rst = 1'b1;
        #1;
        check_output("ar_now", NOP, 0, 0, 0);
        #1;
        rst = 1'b0;
        apply_stimulus(0, 0, 2'b00, 32'h8888_8888, 32'h0, 1);
        check_output("ar_run", 32'h8888_8888, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
